riscv_mdu_issue: RTL and testbench



---
 rtl/riscv_mdu_pkg.sv | 13 +
 rtl/riscv_mdu_reuse_tag.sv | 46 ++++
 rtl/riscv_mdu_issue.sv | 95 +++++++++
 tb/tb_riscv_mdu_issue.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_mdu_pkg.sv
// riscv_mdu_pkg: MDU opcode constants and the issue-stage FSM state type.
package riscv_mdu_pkg;
  localparam int MDU_OP_W = 3;
  localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIV    = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU   = 3'd5;
  localparam logic [MDU_OP_W-1:0] MDU_REM    = 3'd6;
  localparam logic [MDU_OP_W-1:0] MDU_REMU   = 3'd7;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_issue_state_t;
endpackage

// File: rtl/riscv_mdu_reuse_tag.sv
// riscv_mdu_reuse_tag: one-entry cache of the last completed MDU operation (op, a, b, result).
module riscv_mdu_reuse_tag #(
  parameter int XLEN     = 32,
  parameter int MDU_OP_W = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                upd_i,
  input  logic [MDU_OP_W-1:0] upd_op_i,
  input  logic [XLEN-1:0]     upd_a_i,
  input  logic [XLEN-1:0]     upd_b_i,
  input  logic [XLEN-1:0]     upd_res_i,
  input  logic [MDU_OP_W-1:0] lk_op_i,
  input  logic [XLEN-1:0]     lk_a_i,
  input  logic [XLEN-1:0]     lk_b_i,
  output logic                hit_o,
  output logic [XLEN-1:0]     res_o
);
  logic                vld_q, vld_d;
  logic [MDU_OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  always_comb begin
    vld_d = upd_i | vld_q;
    op_d  = upd_i ? upd_op_i : op_q;
    a_d   = upd_i ? upd_a_i : a_q;
    b_d   = upd_i ? upd_b_i : b_q;
    res_d = upd_i ? upd_res_i : res_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      vld_q <= vld_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end
  assign hit_o = vld_q & (op_q == lk_op_i) & (a_q == lk_a_i) & (b_q == lk_b_i);
  assign res_o = res_q;
endmodule

// File: rtl/riscv_mdu_issue.sv
// riscv_mdu_issue: issue/hold stage between execute and the MDU; registers operands, holds result, handles kill.
// Optional result reuse of the last completed operation is enabled by defining RISCV_MDU_REUSE_EN.
module riscv_mdu_issue #(
  parameter int XLEN     = 32,
  parameter int MDU_OP_W = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ex_valid_i,
  input  logic [MDU_OP_W-1:0] ex_op_i,
  input  logic [XLEN-1:0]     ex_a_i,
  input  logic [XLEN-1:0]     ex_b_i,
  input  logic                ex_kill_i,
  input  logic                ex_stall_i,
  output logic                mdu_req_o,
  output logic [MDU_OP_W-1:0] mdu_op_o,
  output logic [XLEN-1:0]     mdu_port_a_o,
  output logic [XLEN-1:0]     mdu_port_b_o,
  output logic                mdu_kill_o,
  output logic                mdu_keep_o,
  input  logic [XLEN-1:0]     mdu_result_i,
  input  logic                mdu_stall_req_i,
  output logic                stall_o,
  output logic                res_valid_o,
  output logic [XLEN-1:0]     res_data_o
);
  import riscv_mdu_pkg::*;
  mdu_issue_state_t    state_q, state_d;
  logic [MDU_OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic                cap, fin, hit;
  logic [XLEN-1:0]     hit_res;
  assign cap = (state_q == IDLE) & ex_valid_i & ~ex_kill_i;
  assign fin = (state_q == BUSY) & ~mdu_stall_req_i & ~ex_kill_i;
`ifdef RISCV_MDU_REUSE_EN
  riscv_mdu_reuse_tag #(.XLEN(XLEN), .MDU_OP_W(MDU_OP_W)) u_tag (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .upd_i     (fin),
    .upd_op_i  (op_q),
    .upd_a_i   (a_q),
    .upd_b_i   (b_q),
    .upd_res_i (mdu_result_i),
    .lk_op_i   (ex_op_i),
    .lk_a_i    (ex_a_i),
    .lk_b_i    (ex_b_i),
    .hit_o     (hit),
    .res_o     (hit_res)
  );
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end
  // kill overrides capture, completion and hold in every state
  always_comb begin
    state_d = ex_kill_i          ? IDLE :
              (state_q == IDLE)  ? (ex_valid_i ? (hit ? DONE : BUSY) : IDLE) :
              (state_q == BUSY)  ? (mdu_stall_req_i ? BUSY : DONE) :
              (ex_stall_i ? DONE : IDLE);
  end
  always_comb begin
    op_d  = cap ? ex_op_i : op_q;
    a_d   = cap ? ex_a_i : a_q;
    b_d   = cap ? ex_b_i : b_q;
    res_d = fin ? mdu_result_i : (cap & hit) ? hit_res : res_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end
  always_comb begin
    mdu_req_o    = state_q == BUSY;
    mdu_kill_o   = ex_kill_i & (state_q == BUSY);
    mdu_keep_o   = state_q == DONE;
    stall_o      = (state_q == BUSY) | ((state_q == IDLE) & ex_valid_i);
    res_valid_o  = state_q == DONE;
    res_data_o   = res_q;
    mdu_op_o     = op_q;
    mdu_port_a_o = a_q;
    mdu_port_b_o = b_q;
  end
endmodule

// File: tb/tb_riscv_mdu_issue.sv
// tb_riscv_mdu_issue: directed self-checking bench for riscv_mdu_issue (reuse path checked when RISCV_MDU_REUSE_EN is defined).
module tb_riscv_mdu_issue;
  import riscv_mdu_pkg::*;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i, ex_kill_i, ex_stall_i, mdu_stall_req_i;
  logic [2:0]  ex_op_i;
  logic [31:0] ex_a_i, ex_b_i, mdu_result_i;
  logic        mdu_req_o, mdu_kill_o, mdu_keep_o, stall_o, res_valid_o;
  logic [2:0]  mdu_op_o;
  logic [31:0] mdu_port_a_o, mdu_port_b_o, res_data_o;
  int          checks = 0;
  int          failures = 0;
  logic        ok;

  riscv_mdu_issue #(.XLEN(32), .MDU_OP_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ex_valid_i(ex_valid_i), .ex_op_i(ex_op_i),
    .ex_a_i(ex_a_i), .ex_b_i(ex_b_i), .ex_kill_i(ex_kill_i), .ex_stall_i(ex_stall_i),
    .mdu_req_o(mdu_req_o), .mdu_op_o(mdu_op_o), .mdu_port_a_o(mdu_port_a_o),
    .mdu_port_b_o(mdu_port_b_o), .mdu_kill_o(mdu_kill_o), .mdu_keep_o(mdu_keep_o),
    .mdu_result_i(mdu_result_i), .mdu_stall_req_i(mdu_stall_req_i), .stall_o(stall_o),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_valid_i = 1'b1;
    ex_op_i    = op;
    ex_a_i     = a;
    ex_b_i     = b;
  endtask

  initial begin
    rst_i = 1'b1; ex_valid_i = 0; ex_kill_i = 0; ex_stall_i = 0; mdu_stall_req_i = 0;
    ex_op_i = 0; ex_a_i = 0; ex_b_i = 0; mdu_result_i = 0;
    tick(); tick();
    check("rst_req", {31'd0, mdu_req_o}, 0);
    check("rst_stall", {31'd0, stall_o}, 0);
    check("rst_valid", {31'd0, res_valid_o}, 0);
    check("rst_keep", {31'd0, mdu_keep_o}, 0);
    check("rst_data", res_data_o, 0);
    check("rst_a", mdu_port_a_o, 0);
    rst_i = 1'b0;
    tick();
    // MUL 7*6, zero MDU stall
    issue(MDU_MUL, 7, 6); mdu_stall_req_i = 0; mdu_result_i = 42;
    #1;
    check("mul_c0_stall", {31'd0, stall_o}, 1);
    check("mul_c0_req", {31'd0, mdu_req_o}, 0);
    tick(); ex_valid_i = 0; #1;
    check("mul_c1_req", {31'd0, mdu_req_o}, 1);
    check("mul_c1_stall", {31'd0, stall_o}, 1);
    check("mul_c1_op", {29'd0, mdu_op_o}, {29'd0, MDU_MUL});
    check("mul_c1_a", mdu_port_a_o, 7);
    check("mul_c1_b", mdu_port_b_o, 6);
    check("mul_c1_valid", {31'd0, res_valid_o}, 0);
    tick(); #1;
    check("mul_c2_valid", {31'd0, res_valid_o}, 1);
    check("mul_c2_data", res_data_o, 42);
    check("mul_c2_keep", {31'd0, mdu_keep_o}, 1);
    check("mul_c2_req", {31'd0, mdu_req_o}, 0);
    check("mul_c2_stall", {31'd0, stall_o}, 0);
    tick(); #1;
    check("mul_idle_valid", {31'd0, res_valid_o}, 0);
    check("mul_idle_hold", res_data_o, 42);
    // DIV 100/7, 33 MDU stall cycles
    issue(MDU_DIV, 100, 7); mdu_stall_req_i = 1; mdu_result_i = 32'hdead;
    tick(); ex_valid_i = 0; ex_a_i = 32'h55; ex_b_i = 32'h66;
    ok = 1'b1;
    for (int i = 0; i < 33; i++) begin
      #1;
      ok &= mdu_req_o && stall_o && !res_valid_o && mdu_port_a_o == 100 && mdu_port_b_o == 7 && mdu_op_o == MDU_DIV;
      tick();
    end
    check("div_stable", {31'd0, ok}, 1);
    mdu_stall_req_i = 0; mdu_result_i = 14; #1;
    check("div_last_req", {31'd0, mdu_req_o}, 1);
    tick(); #1;
    check("div_valid", {31'd0, res_valid_o}, 1);
    check("div_data", res_data_o, 14);
    tick(); #1;
    check("div_one_cycle", {31'd0, res_valid_o}, 0);
    // REM 100/7 completing under a 5-cycle downstream stall
    issue(MDU_REM, 100, 7); mdu_result_i = 2;
    tick(); ex_valid_i = 0;
    tick(); mdu_result_i = 32'hbad;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ex_stall_i = (i < 5); #1;
      ok &= res_valid_o && res_data_o == 2 && mdu_keep_o && !mdu_req_o && !stall_o;
      tick();
    end
    ex_stall_i = 0;
    check("rem_hold", {31'd0, ok}, 1);
    check("rem_released", {31'd0, res_valid_o}, 0);
    check("rem_data_kept", res_data_o, 2);
    // DIVU killed at cycle 10
    issue(MDU_DIVU, 50, 5); mdu_stall_req_i = 1;
    tick(); ex_valid_i = 0;
    repeat (9) tick();
    ex_kill_i = 1; #1;
    check("divu_kill_o", {31'd0, mdu_kill_o}, 1);
    tick(); ex_kill_i = 0; #1;
    check("divu_c11_req", {31'd0, mdu_req_o}, 0);
    check("divu_c11_stall", {31'd0, stall_o}, 0);
    check("divu_c11_valid", {31'd0, res_valid_o}, 0);
    check("divu_c11_killo", {31'd0, mdu_kill_o}, 0);
    tick(); #1;
    check("divu_no_valid", {31'd0, res_valid_o}, 0);
    // kill in IDLE with a valid instruction: nothing captured
    issue(MDU_MUL, 3, 3); ex_kill_i = 1; #1;
    check("idle_kill_killo", {31'd0, mdu_kill_o}, 0);
    tick(); ex_valid_i = 0; ex_kill_i = 0; #1;
    check("idle_kill_req", {31'd0, mdu_req_o}, 0);
    check("idle_kill_op", {29'd0, mdu_op_o}, {29'd0, MDU_DIVU});
    check("idle_kill_a", mdu_port_a_o, 50);
    // completion and kill together: kill wins
    issue(MDU_MULH, 5, 5); mdu_stall_req_i = 0; mdu_result_i = 32'h1234;
    tick(); ex_valid_i = 0; ex_kill_i = 1; #1;
    check("fin_kill_killo", {31'd0, mdu_kill_o}, 1);
    tick(); ex_kill_i = 0; #1;
    check("fin_kill_valid", {31'd0, res_valid_o}, 0);
    check("fin_kill_data", res_data_o, 2);
    // kill in DONE discards the result
    issue(MDU_MULHSU, 8, 9); mdu_result_i = 32'h77;
    tick(); ex_valid_i = 0;
    tick(); #1;
    check("done_kill_pre", res_data_o, 32'h77);
    ex_stall_i = 1; ex_kill_i = 1; #1;
    check("done_kill_killo", {31'd0, mdu_kill_o}, 0);
    tick(); ex_stall_i = 0; ex_kill_i = 0; #1;
    check("done_kill_valid", {31'd0, res_valid_o}, 0);
    // asynchronous reset mid-BUSY
    issue(MDU_DIV, 1000, 10); mdu_stall_req_i = 1;
    tick(); ex_valid_i = 0;
    tick(); #1;
    check("rstmid_req_pre", {31'd0, mdu_req_o}, 1);
    rst_i = 1; #1;
    check("rstmid_req", {31'd0, mdu_req_o}, 0);
    check("rstmid_stall", {31'd0, stall_o}, 0);
    check("rstmid_data", res_data_o, 0);
    #1 rst_i = 0;
    issue(MDU_DIV, 9, 3); mdu_stall_req_i = 0; mdu_result_i = 3;
    tick(); ex_valid_i = 0; #1;
    check("div93_req", {31'd0, mdu_req_o}, 1);
    check("div93_a", mdu_port_a_o, 9);
    tick(); #1;
    check("div93_valid", {31'd0, res_valid_o}, 1);
    check("div93_data", res_data_o, 3);
    tick();
    // MULHU 0xFFFFFFFF*2 twice
    issue(MDU_MULHU, 32'hffffffff, 2); mdu_result_i = 1;
    tick(); ex_valid_i = 0;
    tick(); #1;
    check("mulhu1_data", res_data_o, 1);
    tick();
    issue(MDU_MULHU, 32'hffffffff, 2); mdu_result_i = 32'hbad; mdu_stall_req_i = 1; #1;
    check("mulhu2_c0_req", {31'd0, mdu_req_o}, 0);
    tick(); ex_valid_i = 0; #1;
`ifdef RISCV_MDU_REUSE_EN
    check("mulhu2_reuse_req", {31'd0, mdu_req_o}, 0);
    check("mulhu2_reuse_valid", {31'd0, res_valid_o}, 1);
    check("mulhu2_reuse_data", res_data_o, 1);
    tick();
`else
    check("mulhu2_busy_req", {31'd0, mdu_req_o}, 1);
    check("mulhu2_busy_valid", {31'd0, res_valid_o}, 0);
    mdu_stall_req_i = 0; mdu_result_i = 1;
    tick(); #1;
    check("mulhu2_data", res_data_o, 1);
    tick();
`endif
    #1;
    check("final_idle", {31'd0, res_valid_o}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
